// File: rtl/mul_seq.sv
// Sequential unsigned shift-add multiplier: SIZE x SIZE -> 2*SIZE product over SIZE
// iteration cycles, with a one-cycle P_we strobe when the product register updates.
module mul_seq #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start,
  input  logic [SIZE-1:0]   A,
  input  logic [SIZE-1:0]   B,
  output logic              busy,
  output logic [2*SIZE-1:0] P,
  output logic              P_we
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [SIZE-1:0]   mcand_reg, mcand_next;
  logic [SIZE-1:0]   mplier_reg, mplier_next;
  logic [SIZE-1:0]   acc_hi_reg, acc_hi_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [2*SIZE-1:0] p_reg, p_next;
  logic [SIZE:0]     sum;
  logic [2*SIZE-1:0] shifted;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_hi_reg <= '0;
      count_reg  <= '0;
      p_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_hi_reg <= acc_hi_next;
      count_reg  <= count_next;
      p_reg      <= p_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_hi_next = acc_hi_reg;
    count_next  = count_reg;
    p_next      = p_reg;

    sum     = {1'b0, acc_hi_reg} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
    // Low product bits fall into the vacated top of the multiplier register
    shifted = {sum, mplier_reg[SIZE-1:1]};

    case (state_reg)
      IDLE: begin
        if (start) begin
          mcand_next  = A;
          mplier_next = B;
          acc_hi_next = '0;
          count_next  = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        acc_hi_next = shifted[2*SIZE-1:SIZE];
        mplier_next = shifted[SIZE-1:0];
        count_next  = count_reg + 1'b1;
        if (count_reg == LAST) begin
          p_next     = shifted;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign P_we = (state_reg == DONE);
  assign P    = p_reg;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: vector table of single operations plus hand-written
// sequences for ignored inputs, mid-run reset and back-to-back operation.
module tb_mul_seq;

  logic        clk;
  logic        nReset;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic [15:0] P;
  logic        P_we;

  int checks;
  int failures;

  mul_seq #(.SIZE(8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .P      (P),
    .P_we   (P_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Single operation, inputs driven and outputs sampled on falling edges
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p);
    int edges;
    int busy_cycles;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cycles = busy ? 1 : 0;
    while (!P_we && edges < 20) begin
      @(negedge clk);
      edges++;
      if (busy) busy_cycles++;
    end
    check("latency", edges, 8);
    check("product", P, exp_p);
    @(negedge clk);
    check("pwe_width", P_we, 0);
    check("busy_cycles", busy_cycles, 9);
    check("busy_after", busy, 0);
    $display("op A=%0d B=%0d P=%0h edges=%0d busy_cycles=%0d", a, b, P, edges, busy_cycles);
  endtask

  initial begin
    int pulses;
    int t1;
    int t2;
    logic [15:0] p1;
    logic [15:0] p2;
    bit hold_ok;

    checks = 0;
    failures = 0;
    nReset = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  exp_p: 16'h008F};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp_p: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, exp_p: 16'h0000};
    vecs[3] = '{a: 8'd1,   b: 8'd128, exp_p: 16'h0080};

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_p", P, 0);
    check("reset_pwe", P_we, 0);
    nReset = 1'b1;

    for (int i = 0; i < 4; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p);

    // Inputs and start changing mid-run must be ignored
    @(negedge clk);
    A = 8'd6; B = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    A = 8'd99; B = 8'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    p1 = '0;
    for (int c = 0; c < 20; c++) begin
      if (P_we) begin
        pulses++;
        p1 = P;
      end
      @(negedge clk);
    end
    check("ignored_pulses", pulses, 1);
    check("ignored_product", p1, 42);
    check("ignored_idle", busy, 0);
    $display("ignored-inputs op P=%0d pulses=%0d", p1, pulses);

    // Reset after iteration 4 aborts the operation silently
    @(negedge clk);
    A = 8'd200; B = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_p", P, 0);
    check("abort_pwe", P_we, 0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (P_we) pulses++;
      @(negedge clk);
    end
    check("abort_no_pulse", pulses, 0);
    $display("abort op busy=%0d P=%0h pulses=%0d", busy, P, pulses);
    run_op(8'd7, 8'd6, 16'd42);

    // Back-to-back with start held high
    @(negedge clk);
    A = 8'd3; B = 8'd5; start = 1'b1;
    @(negedge clk);
    check("b2b_busy_rise", busy, 1);
    A = 8'd10; B = 8'd10;
    t1 = -1;
    t2 = -1;
    p1 = '0;
    p2 = '0;
    hold_ok = 1'b1;
    for (int c = 0; c < 30 && t2 < 0; c++) begin
      if (P_we) begin
        if (t1 < 0) begin
          t1 = c; p1 = P;
        end else begin
          t2 = c; p2 = P;
        end
      end else if (t1 >= 0 && P !== 16'd15) begin
        hold_ok = 1'b0;
      end
      if (t2 < 0) @(negedge clk);
    end
    start = 1'b0;
    check("b2b_first", p1, 15);
    check("b2b_second", p2, 100);
    check("b2b_spacing", t2 - t1, 10);
    check("b2b_hold", hold_ok, 1);
    $display("back-to-back P1=%0d P2=%0d spacing=%0d", p1, p2, t2 - t1);
    repeat (12) @(negedge clk);
    check("b2b_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
